// File: rtl/spm_resp_pkg.sv
// Shared definitions for the scratch-pad memory responder.
//   - active-low strobe levels (ENABLE_/DISABLE_)
//   - bus direction encodings (READ/WRITE)
//   - data/address widths and the FSM state encodings
//   - helper that flags a word address outside the populated array
package spm_resp_pkg;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  localparam int WORD_DATA_W = 32;
  localparam int SPM_ADDR_W  = 12;
  localparam int BUS_ADDR_W  = 30;
  localparam int WAIT_CNT_W  = 4;

  typedef enum logic [1:0] {
    SPM_ST_IDLE   = 2'd0,
    SPM_ST_ACCESS = 2'd1,
    SPM_ST_RESP   = 2'd2
  } spm_state_e;

  // True when any word-address bit above the decoded range is set.
  function automatic logic addr_out_of_range(input logic [BUS_ADDR_W-1:0] addr,
                                             input int unsigned          aw);
    return (addr >> aw) != '0;
  endfunction

endpackage

// File: rtl/spm_resp_ram.sv
// Single-port synchronous RAM backing the scratch-pad.
//   clk     : clock
//   en      : access enable; nothing happens when low
//   we      : 1 = write wr_data to addr, 0 = read addr into rd_data
//   addr    : word address
//   wr_data : write data
//   rd_data : registered read data, valid the cycle after a read access
// Contents are never cleared; rd_data holds its value between reads.
module spm_ram #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_data
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wr_data;
      end else begin
        rd_data <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/spm_resp.sv
// Scratch-pad memory responder: accepts one request per IDLE cycle on an
// active-low address strobe, performs the access after WAIT_CYCLES extra
// cycles and answers with a one-cycle active-low ready pulse.
//   clk         : clock, all state on rising edge
//   reset_      : synchronous active-low reset
//   spm_addr    : 30-bit word address
//   spm_as_     : address strobe, active-low
//   spm_rw      : READ / WRITE
//   spm_wr_data : write data
//   spm_rd_data : read data, non-zero only in the response cycle of a good read
//   spm_rdy_    : response ready, active-low, one cycle per transaction
//   spm_err_    : address error, active-low, only together with spm_rdy_
module spm_resp
  import spm_resp_pkg::*;
#(
  parameter int ADDR_W      = SPM_ADDR_W,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   reset_,
  input  logic [BUS_ADDR_W-1:0]  spm_addr,
  input  logic                   spm_as_,
  input  logic                   spm_rw,
  input  logic [WORD_DATA_W-1:0] spm_wr_data,
  output logic [WORD_DATA_W-1:0] spm_rd_data,
  output logic                   spm_rdy_,
  output logic                   spm_err_
);

  // Wait counts above 15 do not fit the counter; only the low bits are used.
  localparam logic [WAIT_CNT_W-1:0] WAIT_LD = WAIT_CNT_W'(WAIT_CYCLES);

  spm_state_e                 state_q, state_d;
  logic [BUS_ADDR_W-1:0]      addr_q,  addr_d;
  logic                       rw_q,    rw_d;
  logic [WORD_DATA_W-1:0]     wdata_q, wdata_d;
  logic [WAIT_CNT_W-1:0]      wait_q,  wait_d;

  logic                       addr_err;
  logic                       ram_en;
  logic [WORD_DATA_W-1:0]     ram_rd_data;

  assign addr_err = addr_out_of_range(addr_q, ADDR_W);

  // Gating with reset_ aborts a write whose commit edge coincides with reset.
  assign ram_en = reset_ && (state_q == SPM_ST_ACCESS) && (wait_q == '0) && !addr_err;

  spm_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .en      (ram_en),
    .we      (rw_q == WRITE),
    .addr    (addr_q[ADDR_W-1:0]),
    .wr_data (wdata_q),
    .rd_data (ram_rd_data)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    wait_d  = wait_q;
    unique case (state_q)
      SPM_ST_IDLE: begin
        if (spm_as_ == ENABLE_) begin
          addr_d  = spm_addr;
          rw_d    = spm_rw;
          wdata_d = spm_wr_data;
          wait_d  = WAIT_LD;
          state_d = SPM_ST_ACCESS;
        end
      end
      SPM_ST_ACCESS: begin
        if (wait_q != '0) begin
          wait_d = wait_q - 1'b1;
        end else begin
          state_d = SPM_ST_RESP;
        end
      end
      SPM_ST_RESP: begin
        // Strobe is not looked at here; a held request is re-sampled in IDLE.
        state_d = SPM_ST_IDLE;
      end
      default: begin
        state_d = SPM_ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q <= SPM_ST_IDLE;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    spm_rdy_    = DISABLE_;
    spm_err_    = DISABLE_;
    spm_rd_data = '0;
    if (state_q == SPM_ST_RESP) begin
      spm_rdy_ = ENABLE_;
      if (addr_err) begin
        spm_err_ = ENABLE_;
      end else if (rw_q == READ) begin
        spm_rd_data = ram_rd_data;
      end
    end
  end

endmodule

// File: doc/spm_resp.md
SPM_RESP -- requirements
Module: spm_resp

Interface
REQ-001 Parameter ADDR_W, default 12, word-address bits decoded; the array depth SHALL be 2^ADDR_W words (16 KB).
REQ-002 Parameter WAIT_CYCLES, default 0, extra access cycles inserted before each response; the legal range SHALL be 0..15.
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset_, input, 1: synchronous active-low reset.
REQ-006 Port spm_addr, input, 30: word address from the initiator.
REQ-007 Port spm_as_, input, 1: address strobe, active-low (ENABLE_).
REQ-008 Port spm_rw, input, 1: READ or WRITE, using the shared header values.
REQ-009 Port spm_wr_data, input, 32: write data.
REQ-010 Port spm_rd_data, output, 32: read data; it SHALL be valid only while spm_rdy_ is low.
REQ-011 Port spm_rdy_, output, 1: response ready, active-low, one-cycle pulse per transaction.
REQ-012 Port spm_err_, output, 1: address error, active-low, asserted only together with spm_rdy_.

Function
REQ-013 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-014 IDLE: if spm_as_ == ENABLE_ is sampled, the block SHALL latch addr, rw and wr_data, load wait_cnt = WAIT_CYCLES, and go to ACCESS; otherwise it SHALL stay in IDLE.
REQ-015 ACCESS with wait_cnt != 0: the block SHALL decrement wait_cnt and stay in ACCESS; no array enable is driven.
REQ-016 ACCESS with wait_cnt == 0: the block SHALL drive the array enable for one cycle and go to RESP; a write commits and a read captures data at that edge.
REQ-017 RESP: the block SHALL drive spm_rdy_ = ENABLE_ for exactly that cycle, then return to IDLE unconditionally.
REQ-018 Latency from the edge sampling spm_as_ to the RESP cycle SHALL be 2 + WAIT_CYCLES cycles.
REQ-019 Read response: spm_rd_data SHALL equal the word at the latched address.
REQ-020 Write response: spm_rd_data SHALL be 32'h0.
REQ-021 Outside RESP, spm_rd_data SHALL be 32'h0.
REQ-022 If latched addr[29:ADDR_W] != 0: no array enable SHALL be driven (no write, no read), spm_rd_data SHALL be 0, and spm_err_ and spm_rdy_ SHALL both be ENABLE_ in RESP.
REQ-023 Changes to any input during ACCESS or RESP SHALL be ignored, including deassertion of spm_as_; the latched transaction completes.
REQ-024 spm_as_ still asserted in RESP SHALL NOT start a new transaction; it is sampled again in IDLE, so back-to-back requests cost one IDLE cycle each.
REQ-025 Address wrap: addr[ADDR_W-1:0] SHALL index the array directly with no offset; the top word (2^ADDR_W - 1) is legal.

Reset
REQ-026 While reset_ is low at an edge, the state SHALL become IDLE, wait_cnt = 0, and the latches SHALL clear to 0.
REQ-027 Reset values: spm_rdy_ = DISABLE_, spm_err_ = DISABLE_, spm_rd_data = 0.
REQ-028 The array enable SHALL be gated by reset_, so a reset asserted in the committing ACCESS cycle aborts the write.
REQ-029 Array contents SHALL NOT be cleared by reset.

Structure
REQ-030 ENABLE_, DISABLE_, READ, WRITE, WORD_DATA_W = 32, SPM_ADDR_W = 12 and the state encodings SPM_ST_IDLE/ACCESS/RESP SHALL live in the shared headers (stddef.h/cpu.h).
REQ-031 The array SHALL be sub-module spm_ram: single-port synchronous RAM with 32-bit width, 2^ADDR_W depth, ports clk, en, we, addr, wr_data and rd_data, and one-cycle read.

Verification
REQ-032 WAIT_CYCLES=0: write 0xDEADBEEF to addr 0x005, then read 0x005 -> each spm_rdy_ pulse exactly 2 cycles after the request edge; read returns 0xDEADBEEF; write response data is 0.
REQ-033 WAIT_CYCLES=3: read addr 0x000 after writing 0x12345678 -> spm_rdy_ arrives 5 cycles after the request; data is 0x12345678; spm_rdy_ is high in all other cycles.
REQ-034 Read addr 0x0001000 (bit 12 set) -> spm_err_ and spm_rdy_ both low in the same cycle; data is 0; a follow-up read of 0x000 confirms it is unchanged.
REQ-035 spm_as_ held low continuously for 3 writes to 0xFFF, 0x000, 0x001 -> responses arrive at 3-cycle spacing; all three words read back correctly; the 0xFFF to 0x000 wrap does not alias.
REQ-036 Pulse reset_ low in the ACCESS cycle of a write of 0xAAAAAAAA to 0x010, where the word previously held 0x55555555 -> no spm_rdy_; the next read returns 0x55555555.
REQ-037 Deassert spm_as_ and change spm_addr during ACCESS -> the original transaction completes on the original address.
